// File: rtl/ltc2387_cnv_scheduler.sv
// LTC2387 conversion scheduler: CNV timing, sample holding register and error flags.
// Optional per-conversion watchdog enabled by defining LTC2387_CNV_TIMEOUT_EN.
`timescale 1ns/1ps
module ltc2387_cnv_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_period,
  input  logic [7:0]  i_cnv_high,
  input  logic [15:0] i_burst_len,
  output logic        o_cnv,
  input  logic [15:0] i_adc_data_in,
  input  logic        i_adc_data_valid_in,
  output logic [15:0] o_sample_data,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_sample_count,
  output logic        o_overrun,
  output logic        o_missed_err,
  output logic        o_timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_FLUSH} state_t;

  localparam logic [15:0] LP_TMO_M1 = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_cnv, r_busy, r_done, r_stop_seen;
  logic [15:0] r_period_eff, r_high_eff, r_burst, r_issued, r_cnt;
  logic [15:0] r_sample_data, r_sample_count;
  logic        r_sample_valid, r_overrun, r_missed, r_pending;

  logic [15:0] w_period_eff, w_high_min1, w_high_eff;
  logic        w_start, w_last, w_rise, w_load, w_drop, w_accept, w_wd_fire;

  assign w_period_eff = (i_period < 16'd4) ? 16'd4 : i_period;
  assign w_high_min1  = (i_cnv_high == 8'd0) ? 16'd1 : {8'd0, i_cnv_high};
  assign w_high_eff   = (w_high_min1 > (w_period_eff - 16'd2)) ? (w_period_eff - 16'd2) : w_high_min1;

  assign w_start  = (r_state == S_IDLE) && i_start;
  // Stop arriving on the final LOW cycle still ends the run at this period boundary.
  assign w_last   = r_stop_seen || i_stop || ((r_burst != 16'd0) && (r_issued == r_burst));
  assign w_rise   = w_start || ((r_state == S_LOW) && (r_cnt == 16'd0) && !w_last);
  assign w_accept = r_sample_valid && i_sample_ready;
  assign w_load   = i_adc_data_valid_in && (!r_sample_valid || i_sample_ready);
  assign w_drop   = i_adc_data_valid_in && r_sample_valid && !i_sample_ready;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnv        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_period_eff <= 16'd4;
      r_high_eff   <= 16'd1;
      r_burst      <= 16'd0;
      r_issued     <= 16'd0;
      r_cnt        <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_HIGH;
            r_cnv        <= 1'b1;
            r_busy       <= 1'b1;
            r_period_eff <= w_period_eff;
            r_high_eff   <= w_high_eff;
            r_burst      <= i_burst_len;
            r_issued     <= 16'd1;
            r_stop_seen  <= i_stop;
            r_cnt        <= w_high_eff - 16'd1;
          end
        end
        S_HIGH: begin
          if (i_stop) r_stop_seen <= 1'b1;
          if (r_cnt == 16'd0) begin
            r_state <= S_LOW;
            r_cnv   <= 1'b0;
            r_cnt   <= r_period_eff - r_high_eff - 16'd1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_LOW: begin
          if (i_stop) r_stop_seen <= 1'b1;
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (w_last) begin
            r_state <= S_FLUSH;
            r_cnt   <= 16'd0;
          end else begin
            r_state  <= S_HIGH;
            r_cnv    <= 1'b1;
            r_cnt    <= r_high_eff - 16'd1;
            r_issued <= r_issued + 16'd1;
          end
        end
        S_FLUSH: begin
          if (i_adc_data_valid_in || (r_cnt == LP_TMO_M1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnv   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A start clears the run's counters and flags while still honouring a same-cycle strobe.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sample_data  <= 16'd0;
      r_sample_valid <= 1'b0;
      r_sample_count <= 16'd0;
      r_overrun      <= 1'b0;
      r_missed       <= 1'b0;
      r_pending      <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample_data  <= i_adc_data_in;
        r_sample_valid <= 1'b1;
      end else if (w_accept) begin
        r_sample_valid <= 1'b0;
      end
      r_sample_count <= (w_start ? 16'd0 : r_sample_count) + {15'd0, w_load};
      r_overrun      <= (!w_start && r_overrun) || w_drop;
      if (w_rise) begin
        r_pending <= 1'b1;
        r_missed  <= !w_start && (r_missed || (r_pending && !i_adc_data_valid_in));
      end else if (i_adc_data_valid_in || w_wd_fire) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef LTC2387_CNV_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_timeout;

  assign w_wd_fire = r_pending && !w_rise && !i_adc_data_valid_in && (r_wd == LP_TMO_M1);

  // Watchdog counts cycles since the latest CNV rise while its sample is outstanding.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wd      <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_rise) begin
        r_wd <= 16'd0;
      end else if (r_pending && !i_adc_data_valid_in) begin
        r_wd <= r_wd + 16'd1;
      end
      if (w_start) begin
        r_timeout <= 1'b0;
      end else if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout;
`else
  assign w_wd_fire     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_cnv          = r_cnv;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sample_data  = r_sample_data;
  assign o_sample_valid = r_sample_valid;
  assign o_sample_count = r_sample_count;
  assign o_overrun      = r_overrun;
  assign o_missed_err   = r_missed;

endmodule

// File: tb/tb_ltc2387_cnv_scheduler.sv
// Bench for ltc2387_cnv_scheduler: timeline model derived from start time and config, checked every cycle.
`timescale 1ns/1ps
module tb_ltc2387_cnv_scheduler;
  localparam int TMO = 64;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, adc_valid = 1'b0, ready = 1'b1;
  logic [15:0] period = 16'd10, burst = 16'd0, adc_data = 16'd0;
  logic [7:0]  cnv_high = 8'd3;
  logic        o_cnv, o_sv, o_busy, o_done, o_ovr, o_miss, o_tmo;
  logic [15:0] o_sd, o_cnt;

  ltc2387_cnv_scheduler #(.TIMEOUT(TMO)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
    .i_period(period), .i_cnv_high(cnv_high), .i_burst_len(burst),
    .o_cnv(o_cnv), .i_adc_data_in(adc_data), .i_adc_data_valid_in(adc_valid),
    .o_sample_data(o_sd), .o_sample_valid(o_sv), .i_sample_ready(ready),
    .o_busy(o_busy), .o_done(o_done), .o_sample_count(o_cnt),
    .o_overrun(o_ovr), .o_missed_err(o_miss), .o_timeout_err(o_tmo));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  // model state: run timeline and expected outputs
  bit     m_run = 1'b0, m_pend = 1'b0;
  longint m_S = 0, m_P = 4, m_H = 1, m_N = 1, m_rise_cyc = 0;
  logic        exp_cnv = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_sv = 1'b0;
  logic        exp_ovr = 1'b0, exp_miss = 1'b0, exp_tmo = 1'b0;
  logic [15:0] exp_sd = 16'd0, exp_cnt = 16'd0, data_ctr = 16'hC000;
  // ADC responder and DUT waveform statistics
  bit     resp_en = 1'b0;
  longint resp_S = 0, resp_P = 10, resp_N = 0, resp_dly = 6, run_S = 0;
  int     rises, high_cycles, done_cnt, sp_min, sp_max, last_rise, done_cyc;
  logic   cnv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rises = 0; high_cycles = 0; done_cnt = 0; sp_min = 99999; sp_max = 0; last_rise = -1; done_cyc = -1;
  endtask

  // Advance the model by the edge just taken, using the inputs the DUT sampled there.
  task automatic model_step();
    longint d, f0;
    bit rise, first;
    rise = 1'b0; first = 1'b0;
    exp_done = 1'b0;
    if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_S = cyc;
        m_P = (period < 16'd4) ? 4 : longint'(period);
        m_H = (cnv_high == 8'd0) ? 1 : longint'(cnv_high);
        if (m_H > m_P - 2) m_H = m_P - 2;
        m_N = (burst == 16'd0) ? (longint'(1) << 40) : longint'(burst);
        if (stop) m_N = 1;
        rise = 1'b1; first = 1'b1;
        exp_cnt = 16'd0; exp_ovr = 1'b0; exp_miss = 1'b0; exp_tmo = 1'b0;
      end
    end else begin
      d = cyc - m_S;
      if (stop && d < m_N * m_P) m_N = (d + m_P - 1) / m_P;
      if (d < m_N * m_P && d % m_P == 0) rise = 1'b1;
      f0 = m_S + m_N * m_P;
      if (cyc > f0 && (adc_valid || cyc == f0 + TMO)) begin
        m_run = 1'b0; exp_done = 1'b1;
      end
    end
    if (adc_valid) begin
      if (!exp_sv || ready) begin
        exp_sd = adc_data; exp_sv = 1'b1; exp_cnt = exp_cnt + 16'd1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_sv && ready) begin
      exp_sv = 1'b0;
    end
    if (rise) begin
      if (!first && m_pend && !adc_valid) exp_miss = 1'b1;
      m_pend = 1'b1; m_rise_cyc = cyc;
    end else if (adc_valid) begin
      m_pend = 1'b0;
    end
`ifdef LTC2387_CNV_TIMEOUT_EN
    else if (m_pend && cyc == m_rise_cyc + TMO) begin
      exp_tmo = 1'b1; m_pend = 1'b0;
    end
`endif
    exp_busy = m_run;
    d = cyc - m_S;
    exp_cnv = m_run && (d < m_N * m_P) && (d % m_P < m_H);
  endtask

  task automatic tick(input int k);
    longint rel;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_run = 1'b0; m_pend = 1'b0;
        exp_cnv = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_sv = 1'b0;
        exp_ovr = 1'b0; exp_miss = 1'b0; exp_tmo = 1'b0; exp_sd = 16'd0; exp_cnt = 16'd0;
      end else begin
        model_step();
        check("cnv", o_cnv, exp_cnv);
        check("busy", o_busy, exp_busy);
        check("done", o_done, exp_done);
        check("sample_valid", o_sv, exp_sv);
        check("sample_data", o_sd, exp_sd);
        check("sample_count", o_cnt, exp_cnt);
        check("overrun", o_ovr, exp_ovr);
        check("missed_err", o_miss, exp_miss);
        check("timeout_err", o_tmo, exp_tmo);
        if (o_cnv) high_cycles++;
        if (o_cnv && !cnv_prev) begin
          rises++;
          if (last_rise >= 0) begin
            if (cyc - last_rise < sp_min) sp_min = cyc - last_rise;
            if (cyc - last_rise > sp_max) sp_max = cyc - last_rise;
          end
          last_rise = cyc;
        end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
      end
      cnv_prev = o_cnv;
      #1;
      start = 1'b0; stop = 1'b0;
      rel = longint'(cyc + 1) - resp_S - resp_dly;
      adc_valid = resp_en && rel >= 0 && (rel % resp_P == 0) && (rel / resp_P < resp_N);
      if (adc_valid) begin adc_data = data_ctr; data_ctr = data_ctr + 16'd1; end
    end
  endtask

  task automatic do_start(input logic [15:0] p, input logic [7:0] h, input logic [15:0] b, input logic s);
    period = p; cnv_high = h; burst = b; start = 1'b1; stop = s;
    run_S = cyc + 1; resp_S = run_S;
    clear_stats();
    tick(1);
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin tick(1); k++; end
    check("done_seen", done_cnt != 0, 1'b1);
    tick(3);
  endtask

  initial begin
    clear_stats();
    tick(2);
    rst = 1'b0;
    check("rst_cnv", o_cnv, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_sample_valid", o_sv, 1'b0);
    check("rst_sample_data", o_sd, 16'd0);
    check("rst_sample_count", o_cnt, 16'd0);
    check("rst_flags", {o_ovr, o_miss, o_tmo}, 3'b000);
    tick(2);

    // 4-conversion burst; config changes after start must not matter
    resp_en = 1'b1; resp_P = 10; resp_N = 4; resp_dly = 6;
    do_start(16'd10, 8'd3, 16'd4, 1'b0);
    period = 16'd7; cnv_high = 8'd1; burst = 16'd9;
    wait_done(300);
    check("burst_pulses", rises, 4);
    check("burst_high_cycles", high_cycles, 12);
    check("burst_spacing_min", sp_min, 10);
    check("burst_spacing_max", sp_max, 10);
    check("burst_count", o_cnt, 16'd4);
    check("burst_done_once", done_cnt, 1);
    check("burst_flags", {o_ovr, o_miss, o_tmo}, 3'b000);

    // clamping: period 2 -> 4, high 0 -> 1
    resp_P = 4; resp_N = 2; resp_dly = 2;
    do_start(16'd2, 8'd0, 16'd2, 1'b0);
    wait_done(200);
    check("clamp_pulses", rises, 2);
    check("clamp_high_cycles", high_cycles, 2);
    check("clamp_spacing", sp_min, 4);
    // clamping: high 200 with period 5 -> 3
    resp_P = 5; resp_N = 1; resp_dly = 4;
    do_start(16'd5, 8'd200, 16'd1, 1'b0);
    wait_done(200);
    check("clamp_high_max", high_cycles, 3);

    // continuous run stopped after the third rise
    resp_P = 10; resp_N = 3; resp_dly = 6;
    do_start(16'd10, 8'd3, 16'd0, 1'b0);
    for (int k = 0; k < 100 && rises < 3; k++) tick(1);
    stop = 1'b1;
    wait_done(200);
    check("stop_pulses", rises, 3);
    check("stop_done_once", done_cnt, 1);
    // start and stop together: exactly one conversion
    resp_N = 1;
    do_start(16'd10, 8'd3, 16'd0, 1'b1);
    wait_done(200);
    check("startstop_pulses", rises, 1);

    // no strobes: watchdog and FLUSH timeout
    resp_en = 1'b0;
    do_start(16'd100, 8'd3, 16'd1, 1'b0);
    tick(63);
    check("tmo_before", o_tmo, 1'b0);
    tick(1);
`ifdef LTC2387_CNV_TIMEOUT_EN
    check("tmo_at_64", o_tmo, 1'b1);
`else
    check("tmo_at_64", o_tmo, 1'b0);
`endif
    wait_done(300);
    check("flush_exit_cycle", done_cyc - int'(run_S), 164);

    // asynchronous reset while CNV is high
    do_start(16'd10, 8'd3, 16'd0, 1'b0);
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnv", o_cnv, 1'b0);
    check("async_rst_busy", o_busy, 1'b0);
    tick(1);
    rst = 1'b0;
    clear_stats();
    tick(5);
    check("async_rst_no_done", done_cnt, 0);
    check("async_rst_count", o_cnt, 16'd0);

    // overrun with consumer stalled
    ready = 1'b0;
    adc_data = 16'hA5A5; adc_valid = 1'b1;
    tick(3);
    adc_data = 16'h1234; adc_valid = 1'b1;
    tick(2);
    check("ovr_data_held", o_sd, 16'hA5A5);
    check("ovr_valid", o_sv, 1'b1);
    check("ovr_flag", o_ovr, 1'b1);
    check("ovr_count", o_cnt, 16'd1);
    ready = 1'b1;
    tick(2);
    check("ovr_accepted", o_sv, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ltc2387_cnv_scheduler.md
LTC2387_CNV_SCHEDULER -- requirements
Module: ltc2387_cnv_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64, sys_clk cycles allowed from CNV rise to adc_data_valid_in.
REQ-002 sys_clk  in  1  single block clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a run; ignored unless IDLE.
REQ-005 stop  in  1  one-cycle request to end a run after the current conversion period.
REQ-006 period  in  16  conversion period in sys_clk cycles; latched at start.
REQ-007 cnv_high  in  8  CNV high width in sys_clk cycles; latched at start.
REQ-008 burst_len  in  16  conversions per run; 0 = continuous; latched at start.
REQ-009 cnv  out  1  conversion start to ADC, registered.
REQ-010 adc_data_in  in  16  sample from ADC interface.
REQ-011 adc_data_valid_in  in  1  one-cycle strobe qualifying adc_data_in.
REQ-012 sample_data  out  16  held sample to consumer.
REQ-013 sample_valid  out  1  sample_data valid; holds until accepted.
REQ-014 sample_ready  in  1  consumer accept; transfer when sample_valid and sample_ready are both high.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on return to IDLE.
REQ-017 sample_count  out  16  samples captured in current/last run; wraps at 16 bits.
REQ-018 overrun, missed_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-019 States: IDLE, HIGH, LOW, FLUSH.
REQ-020 IDLE + start: latch config, clear sample_count and sticky flags, go HIGH next cycle.
REQ-021 Effective period = max(period, 4); effective high = min(max(cnv_high, 1), period_eff - 2).
REQ-022 HIGH: cnv=1 for exactly high_eff cycles, then LOW.
REQ-023 LOW: cnv=0 for period_eff - high_eff cycles, giving cnv rise-to-rise spacing of exactly period_eff.
REQ-024 LOW end: go FLUSH if issued conversions == burst_len (burst_len != 0) or stop was seen during the run; otherwise go HIGH.
REQ-025 stop in IDLE ignored; stop in HIGH/LOW latched, completes the current period, issues no further CNV.
REQ-026 Pending flag set on each cnv rise and cleared on adc_data_valid_in; a cnv rise while pending sets missed_err.
REQ-027 FLUSH: exit on adc_data_valid_in or after TIMEOUT cycles with no strobe, whichever comes first; on exit go IDLE and pulse done.
REQ-028 adc_data_valid_in with holding register empty, or simultaneous with acceptance: load sample_data, assert sample_valid, increment sample_count.
REQ-029 adc_data_valid_in with sample_valid high and sample_ready low: sample dropped, sample_data unchanged, overrun set, sample_count not incremented.
REQ-030 Strobes accepted in every state; in IDLE with no run they still load/overrun as above.
REQ-031 start and stop in the same IDLE cycle: the run starts and ends after one conversion.
REQ-032 Config inputs changed mid-run have no effect until the next start.

Reset
REQ-033 Reset forces IDLE; cnv, sample_valid, busy, done, overrun, missed_err, timeout_err = 0; sample_data, sample_count = 0.
REQ-034 Reset asserted mid-run drops cnv within the reset assertion, without waiting for a clock edge; the held sample is discarded; no done pulse.

Configuration
REQ-035 Macro LTC2387_CNV_TIMEOUT_EN defined: watchdog per conversion; no adc_data_valid_in within TIMEOUT cycles of cnv rise sets timeout_err, and clears pending.
REQ-036 Macro undefined: timeout_err constant 0, no per-conversion watchdog; FLUSH TIMEOUT exit (REQ-027) retained.

Verification
REQ-037 period=10, cnv_high=3, burst_len=4, valid 6 cycles after each rise, ready=1: exactly 4 cnv pulses, 3 high, rises 10 apart; sample_count=4; done once; no flags.
REQ-038 period=2, cnv_high=0: clamped to period 4, high 1; period=5, cnv_high=200: high 3.
REQ-039 burst_len=0, stop after 3rd rise: 3 pulses total, done after FLUSH; later start in same cycle as stop behaves per REQ-031.
REQ-040 ready=0, two valid strobes: first sample held (e.g. 16'hA5A5), second (16'h1234) dropped, overrun=1, sample_count=1.
REQ-041 No valid strobes, macro defined, TIMEOUT=64, period=100: timeout_err=1 64 cycles after first rise; FLUSH exits after 64 cycles; macro undefined: timeout_err stays 0.
REQ-042 Reset asserted in HIGH: cnv=0 asynchronously, state IDLE, all outputs per REQ-033, no done pulse.
